parity_tx_sched: RTL and testbench

Round-robin scheduler that shares one byte-serializer/parity-generator datapath among `NREQ` requesters. Each request is granted, loaded into the serializer, supervised with a timeout, and completed with a one-cycle result carrying the requester ID, the serializer's parity bit and a locally computed parity cross-check. It sits between the byte producers and the serializer, which exposes a load/data input and a done/parity output.

---
 rtl/parity_tx_sched.sv | 177 +++++++++++++++++
 tb/tb_parity_tx_sched.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/parity_tx_sched.sv
`default_nettype none
// ============================================================================
// Module   : parity_tx_sched
// Brief    : Round-robin scheduler sharing one byte serializer / parity
//            generator among NREQ requesters, with a RUN-phase timeout and
//            a parity cross-check on completion.
// Revision : 1.0 - initial release
// ============================================================================
module parity_tx_sched #(
  parameter int NREQ    = 4,
  parameter int DW      = 8,
  parameter int TIMEOUT = 15,
  localparam int IW     = (NREQ > 1) ? $clog2(NREQ) : 1,
  localparam int TW     = $clog2(TIMEOUT + 1)
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ*DW-1:0] req_data,
  output logic [NREQ-1:0]    grant,
  output logic               busy,
  output logic               done_valid,
  output logic [IW-1:0]      done_id,
  output logic               done_parity,
  output logic               parity_err,
  output logic               timeout_err,
  output logic               ser_load,
  output logic [DW-1:0]      ser_data,
  input  logic               ser_done,
  input  logic               ser_parity
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_LOAD   = 2'd1;
  localparam logic [1:0] S_RUN    = 2'd2;
  localparam logic [1:0] S_REPORT = 2'd3;

  localparam logic [TW-1:0] TCNT_MAX = TW'(TIMEOUT);
  localparam logic [IW-1:0] LAST_ID  = IW'(NREQ - 1);

  logic [1:0]    state;
  logic [1:0]    state_nxt;
  logic [IW-1:0] ptr;
  logic [IW-1:0] cur_id;
  logic [DW-1:0] cur_byte;
  logic          exp_par;
  logic          cap_par;
  logic [TW-1:0] tcnt;

  logic          pick_found;
  logic [IW-1:0] pick_id;
  logic [DW-1:0] pick_byte;
  int            idx;

  // tcnt == 0 marks the blanking cycle right after load; done is ignored there
  logic          run_blank;
  logic          run_expired;

  assign run_blank   = (tcnt == '0);
  assign run_expired = (tcnt == TCNT_MAX);

  // Round-robin pick: first asserted request at or above ptr, wrapping around
  always_comb begin
    pick_found = 1'b0;
    pick_id    = '0;
    pick_byte  = '0;
    idx        = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(ptr) + k;
      if (idx >= NREQ) begin
        idx = idx - NREQ;
      end
      if (!pick_found && req[idx]) begin
        pick_found = 1'b1;
        pick_id    = IW'(idx);
        pick_byte  = req_data[idx*DW +: DW];
      end
    end
  end

  // State register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode; timeout takes priority over a late done
  always_comb begin
    state_nxt = S_IDLE;
    case (state)
      S_IDLE:   state_nxt = pick_found ? S_LOAD : S_IDLE;
      S_LOAD:   state_nxt = S_RUN;
      S_RUN: begin
        if (run_expired) begin
          state_nxt = S_IDLE;
        end else if (!run_blank && ser_done) begin
          state_nxt = S_REPORT;
        end else begin
          state_nxt = S_RUN;
        end
      end
      S_REPORT: state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Transaction datapath: latch the winner, advance ptr, run the timeout counter
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ptr      <= '0;
      cur_id   <= '0;
      cur_byte <= '0;
      exp_par  <= 1'b0;
      cap_par  <= 1'b0;
      tcnt     <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (pick_found) begin
            cur_id   <= pick_id;
            cur_byte <= pick_byte;
            exp_par  <= ^pick_byte;
          end
        end
        S_LOAD: begin
          tcnt <= '0;
          ptr  <= (cur_id == LAST_ID) ? '0 : cur_id + 1'b1;
        end
        S_RUN: begin
          if (!run_expired) begin
            if (!run_blank && ser_done) begin
              cap_par <= ser_parity;
            end else begin
              tcnt <= tcnt + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs decoded purely from registered state
  always_comb begin
    grant       = '0;
    ser_load    = 1'b0;
    busy        = (state != S_IDLE);
    done_valid  = 1'b0;
    done_id     = '0;
    done_parity = 1'b0;
    parity_err  = 1'b0;
    timeout_err = 1'b0;
    case (state)
      S_LOAD: begin
        grant[cur_id] = 1'b1;
        ser_load      = 1'b1;
      end
      S_RUN: begin
        timeout_err = run_expired;
      end
      S_REPORT: begin
        done_valid  = 1'b1;
        done_id     = cur_id;
        done_parity = cap_par;
        parity_err  = cap_par ^ exp_par;
      end
      default: ;
    endcase
  end

  assign ser_data = cur_byte;

endmodule
`default_nettype wire

// File: tb/tb_parity_tx_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_parity_tx_sched
// Brief    : Scoreboard bench for parity_tx_sched with a behavioural
//            serializer model and directed request vectors.
// Revision : 1.0 - initial release
// ============================================================================
module tb_parity_tx_sched;

  localparam int NREQ    = 4;
  localparam int DW      = 8;
  localparam int TIMEOUT = 15;

  logic            clock = 1'b0;
  logic            reset_n;
  logic [3:0]      req;
  logic [31:0]     req_data;
  logic [3:0]      grant;
  logic            busy;
  logic            done_valid;
  logic [1:0]      done_id;
  logic            done_parity;
  logic            parity_err;
  logic            timeout_err;
  logic            ser_load;
  logic [7:0]      ser_data;
  logic            ser_done;
  logic            ser_parity;

  parity_tx_sched #(.NREQ(NREQ), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .req         (req),
    .req_data    (req_data),
    .grant       (grant),
    .busy        (busy),
    .done_valid  (done_valid),
    .done_id     (done_id),
    .done_parity (done_parity),
    .parity_err  (parity_err),
    .timeout_err (timeout_err),
    .ser_load    (ser_load),
    .ser_data    (ser_data),
    .ser_done    (ser_done),
    .ser_parity  (ser_parity)
  );

  always #5 clock = ~clock;

  typedef struct { logic [3:0] g; logic [7:0] d; } gexp_t;
  typedef struct { bit to; int id; bit par; bit perr; int lat; } rexp_t;

  gexp_t gq[$];
  rexp_t rq[$];

  int n_checks  = 0;
  int n_pass    = 0;
  int cyc       = 0;
  int grant_cyc = 0;
  int gcount    = 0;

  // Requesters: want = raised by stimulus, got = granted (dropped unless held)
  logic [3:0] want = 4'd0;
  logic [3:0] got  = 4'd0;
  logic [3:0] hold = 4'd0;
  assign req = want & ~(got & ~hold);

  // Serializer model controls
  int ser_delay = 2;
  bit ser_flip  = 1'b0;
  bit ser_stall = 1'b0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic push_g(input logic [3:0] g, input logic [7:0] d);
    gexp_t e;
    e.g = g;
    e.d = d;
    gq.push_back(e);
  endtask

  task automatic push_r(input bit to, input int id, input bit par, input bit perr, input int lat);
    rexp_t r;
    r.to = to; r.id = id; r.par = par; r.perr = perr; r.lat = lat;
    rq.push_back(r);
  endtask

  // Wait for all expected traffic to retire and the block to go idle
  task automatic drain(input int maxc);
    int k = 0;
    while ((gq.size() != 0 || rq.size() != 0 || busy !== 1'b0) && k < maxc) begin
      @(negedge clock);
      k++;
    end
    chk("drain_in_time", 32'(k < maxc), 32'd1);
    want = 4'd0;
    repeat (2) @(negedge clock);
  endtask

  // Monitor: pops expectations whenever the DUT presents grant/done/timeout
  initial begin
    gexp_t e;
    rexp_t r;
    forever begin
      @(negedge clock);
      got = got & want;
      if (reset_n === 1'b1) begin
        if (grant != 4'd0) begin
          gcount++;
          grant_cyc = cyc;
          got = got | grant;
          if (gq.size() == 0) begin
            chk("unexpected_grant", 32'(grant), 32'd0);
          end else begin
            e = gq.pop_front();
            chk("grant", 32'(grant), 32'(e.g));
            chk("grant_ser_load", 32'(ser_load), 32'd1);
            chk("ser_data", 32'(ser_data), 32'(e.d));
          end
        end
        if (done_valid === 1'b1 || timeout_err === 1'b1) begin
          if (rq.size() == 0) begin
            chk("unexpected_completion", 32'({done_valid, timeout_err}), 32'd0);
          end else begin
            r = rq.pop_front();
            chk("done_valid", 32'(done_valid), 32'(!r.to));
            chk("timeout_err", 32'(timeout_err), 32'(r.to));
            chk("latency", 32'(cyc - grant_cyc), 32'(r.lat));
            if (!r.to) begin
              chk("done_id", 32'(done_id), 32'(r.id));
              chk("done_parity", 32'(done_parity), 32'(r.par));
              chk("parity_err", 32'(parity_err), 32'(r.perr));
            end
          end
        end
      end
    end
  end

  // Serializer model: done after ser_delay cycles, or stuck-high only over blanking
  initial begin
    logic [7:0] b;
    ser_done   = 1'b0;
    ser_parity = 1'b0;
    forever begin
      @(negedge clock);
      if (reset_n === 1'b1 && ser_load === 1'b1) begin
        b = ser_data;
        if (ser_stall) begin
          ser_done = 1'b1;
          repeat (2) @(negedge clock);
          ser_done = 1'b0;
        end else begin
          repeat (ser_delay) @(negedge clock);
          ser_done   = 1'b1;
          ser_parity = (^b) ^ ser_flip;
          @(negedge clock);
          ser_done = 1'b0;
        end
      end
    end
  end

  // Directed stimulus
  initial begin
    int g0;
    int k;
    reset_n  = 1'b0;
    req_data = 32'd0;
    repeat (3) @(negedge clock);
    chk("reset_outputs", 32'({grant, busy, done_valid, done_id, done_parity,
                              parity_err, timeout_err, ser_load, ser_data}), 32'd0);
    reset_n = 1'b1;
    @(negedge clock);

    // Single request, B5 has odd weight, done 9 cycles after load
    ser_delay = 9; ser_flip = 1'b0; ser_stall = 1'b0;
    req_data[7:0] = 8'hB5;
    push_g(4'b0001, 8'hB5);
    push_r(1'b0, 0, 1'b1, 1'b0, 10);
    want = 4'b0001;
    drain(100);

    // Serializer returns wrong parity for 01
    ser_delay = 4; ser_flip = 1'b1;
    req_data[15:8] = 8'h01;
    push_g(4'b0010, 8'h01);
    push_r(1'b0, 1, 1'b0, 1'b1, 5);
    want = 4'b0010;
    drain(100);

    // Done only during blanking -> timeout
    ser_flip = 1'b0; ser_stall = 1'b1;
    req_data[23:16] = 8'h5A;
    push_g(4'b0100, 8'h5A);
    push_r(1'b1, 2, 1'b0, 1'b0, TIMEOUT + 1);
    want = 4'b0100;
    drain(100);
    ser_stall = 1'b0;

    // Next request served normally, earliest done acceptance
    ser_delay = 2;
    req_data[31:24] = 8'h3C;
    push_g(4'b1000, 8'h3C);
    push_r(1'b0, 3, 1'b0, 1'b0, 3);
    want = 4'b1000;
    drain(100);

    // Serve requester 2 so ptr lands on 3
    ser_delay = 5;
    req_data[23:16] = 8'hE1;
    push_g(4'b0100, 8'hE1);
    push_r(1'b0, 2, 1'b0, 1'b0, 6);
    want = 4'b0100;
    drain(100);

    // ptr=3, req=0101 -> wrap to 0, then 2
    ser_delay = 3;
    req_data[7:0]   = 8'hFF;
    req_data[23:16] = 8'h07;
    push_g(4'b0001, 8'hFF);
    push_g(4'b0100, 8'h07);
    push_r(1'b0, 0, 1'b0, 1'b0, 4);
    push_r(1'b0, 2, 1'b1, 1'b0, 4);
    want = 4'b0101;
    drain(200);

    // Reset during RUN drops the transaction and clears ptr
    ser_delay = 9;
    req_data[15:8] = 8'h99;
    push_g(4'b0010, 8'h99);
    want = 4'b0010;
    k = 0;
    while (gq.size() != 0 && k < 50) begin
      @(negedge clock);
      k++;
    end
    chk("mid_grant_seen", 32'(k < 50), 32'd1);
    repeat (2) @(negedge clock);
    reset_n = 1'b0;
    #1;
    chk("reset_mid_outputs", 32'({grant, busy, done_valid, done_id, done_parity,
                                  parity_err, timeout_err, ser_load, ser_data}), 32'd0);
    want = 4'd0;
    repeat (12) @(negedge clock);

    // All four requesting continuously from reset release
    ser_delay = 3;
    req_data = {8'h7F, 8'h00, 8'h80, 8'hA5};
    push_g(4'b0001, 8'hA5); push_r(1'b0, 0, 1'b0, 1'b0, 4);
    push_g(4'b0010, 8'h80); push_r(1'b0, 1, 1'b1, 1'b0, 4);
    push_g(4'b0100, 8'h00); push_r(1'b0, 2, 1'b0, 1'b0, 4);
    push_g(4'b1000, 8'h7F); push_r(1'b0, 3, 1'b1, 1'b0, 4);
    push_g(4'b0001, 8'hA5); push_r(1'b0, 0, 1'b0, 1'b0, 4);
    hold = 4'hF;
    want = 4'hF;
    g0 = gcount;
    reset_n = 1'b1;
    k = 0;
    while (gcount < g0 + 5 && k < 500) begin
      @(negedge clock);
      k++;
    end
    chk("continuous_grants_in_time", 32'(k < 500), 32'd1);
    want = 4'd0;
    hold = 4'd0;
    drain(100);

    chk("scoreboard_empty", 32'(gq.size() + rq.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, passed %0d of %0d", n_pass, n_checks);
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
